// File: rtl/idli_sqi_ctrl.sv
// idli_sqi_ctrl: SQI (quad-SPI) memory controller.
// Turns one request (address, direction, chip select, burst length) into a
// full SQI transaction: command, address, optional dummy periods and a burst
// of data words, with a write-data handshake before every written word.
module idli_sqi_ctrl #(
   parameter int unsigned ADDR_W    = 24,
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned NUM_CS    = 2,
   parameter int unsigned LEN_W     = 4,
   parameter int unsigned DUMMY_CYC = 4,
   parameter logic [7:0]  CMD_RD    = 8'h03,
   parameter logic [7:0]  CMD_WR    = 8'h02,
   localparam int unsigned CS_W     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req_vld,
   output logic              o_req_rdy,
   input  logic              i_req_wr,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [CS_W-1:0]   i_req_cs,
   input  logic [LEN_W-1:0]  i_req_len,
   input  logic              i_wdata_vld,
   output logic              o_wdata_rdy,
   input  logic [DATA_W-1:0] i_wdata,
   output logic              o_rdata_vld,
   output logic [DATA_W-1:0] o_rdata,
   output logic              o_sqi_sck,
   output logic [NUM_CS-1:0] o_sqi_cs_n,
   output logic [3:0]        o_sqi_data,
   output logic              o_sqi_oe,
   input  logic [3:0]        i_sqi_data
);

   localparam int unsigned ADDR_NIBS = ADDR_W / 4;
   localparam int unsigned DATA_NIBS = DATA_W / 4;
   localparam int unsigned SH_W      = (8 + ADDR_W > DATA_W) ? 8 + ADDR_W : DATA_W;
   localparam int unsigned MAX_AD    = (ADDR_NIBS > DATA_NIBS) ? ADDR_NIBS : DATA_NIBS;
   localparam int unsigned MAX_ADD   = (MAX_AD > DUMMY_CYC) ? MAX_AD : DUMMY_CYC;
   localparam int unsigned MAX_N     = (MAX_ADD > 2) ? MAX_ADD : 2;
   localparam int unsigned CNT_W     = $clog2(MAX_N + 1);
   localparam int unsigned DUM_LAST  = (DUMMY_CYC > 0) ? DUMMY_CYC - 1 : 0;

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_WWAIT, S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic               phase_q, phase_d;
   logic [CNT_W-1:0]   nib_q, nib_d;
   logic [LEN_W-1:0]   word_q, word_d;
   logic               wr_q, wr_d;
   logic [CS_W-1:0]    cs_q, cs_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [SH_W-1:0]    sh_q, sh_d;
   logic [DATA_W-1:0]  rx_q, rx_d;
   logic               nib_last;

   logic               sck_d, oe_d, rdy_d, wrdy_d, rvld_d, active_d;
   logic [NUM_CS-1:0]  cs_n_d;
   logic [3:0]         sdata_d;
   logic [DATA_W-1:0]  rdata_d;

   // Next-state: request latch, nibble/phase sequencing and shift registers
   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      nib_d    = nib_q;
      word_d   = word_q;
      wr_d     = wr_q;
      cs_d     = cs_q;
      len_d    = len_q;
      sh_d     = sh_q;
      rx_d     = rx_q;
      rvld_d   = 1'b0;
      rdata_d  = o_rdata;
      nib_last = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_req_vld && o_req_rdy) begin
               wr_d    = i_req_wr;
               cs_d    = i_req_cs;
               len_d   = i_req_len;
               sh_d    = '0;
               sh_d[SH_W-1 -: 8+ADDR_W] = {(i_req_wr ? CMD_WR : CMD_RD), i_req_addr};
               state_d = S_CMD;
               phase_d = 1'b0;
               nib_d   = '0;
               word_d  = '0;
            end
         end
         S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
            phase_d = ~phase_q;
            if (phase_q) begin
               // End of a high SCK period: move on to the next nibble
               sh_d  = sh_q << 4;
               nib_d = nib_q + CNT_W'(1);
               if (state_q == S_DATA && !wr_q)
                  rx_d = (rx_q << 4) | DATA_W'(i_sqi_data);
               case (state_q)
                  S_CMD:   nib_last = (nib_q == CNT_W'(1));
                  S_ADDR:  nib_last = (nib_q == CNT_W'(ADDR_NIBS - 1));
                  S_DUMMY: nib_last = (nib_q == CNT_W'(DUM_LAST));
                  default: nib_last = (nib_q == CNT_W'(DATA_NIBS - 1));
               endcase
               if (nib_last) begin
                  nib_d = '0;
                  case (state_q)
                     S_CMD:   state_d = S_ADDR;
                     S_ADDR:  state_d = wr_q ? S_WWAIT : ((DUMMY_CYC > 0) ? S_DUMMY : S_DATA);
                     S_DUMMY: state_d = S_DATA;
                     default: begin
                        if (!wr_q) begin
                           rvld_d  = 1'b1;
                           rdata_d = rx_d;
                        end
                        if (word_q == len_q) begin
                           state_d = S_DONE;
                        end else begin
                           word_d  = word_q + LEN_W'(1);
                           state_d = wr_q ? S_WWAIT : S_DATA;
                        end
                     end
                  endcase
               end
            end
         end
         S_WWAIT: begin
            if (i_wdata_vld && o_wdata_rdy) begin
               sh_d    = '0;
               sh_d[SH_W-1 -: DATA_W] = i_wdata;
               state_d = S_DATA;
               phase_d = 1'b0;
               nib_d   = '0;
            end
         end
         S_DONE: begin
            if (nib_q == CNT_W'(1)) begin
               state_d = S_IDLE;
               nib_d   = '0;
            end else begin
               nib_d = nib_q + CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode from the next state, so every pin comes straight off a flop
   always_comb begin
      active_d = (state_d == S_CMD) || (state_d == S_ADDR) || (state_d == S_DUMMY) ||
                 (state_d == S_DATA) || (state_d == S_WWAIT);
      sck_d    = phase_d && ((state_d == S_CMD) || (state_d == S_ADDR) ||
                             (state_d == S_DUMMY) || (state_d == S_DATA));
      oe_d     = (state_d == S_CMD) || (state_d == S_ADDR) ||
                 (wr_d && ((state_d == S_DATA) || (state_d == S_WWAIT)));
      sdata_d  = (oe_d && state_d != S_WWAIT) ? sh_d[SH_W-1 -: 4] : 4'h0;
      rdy_d    = (state_d == S_IDLE);
      wrdy_d   = (state_d == S_WWAIT);
      cs_n_d   = '1;
      // An out-of-range select matches no bit, so the bus runs with no device selected
      for (int i = 0; i < NUM_CS; i++) begin
         if (active_d && cs_d == CS_W'(i))
            cs_n_d[i] = 1'b0;
      end
   end

   // Control state and registered outputs, cleared by reset
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q     <= S_IDLE;
         phase_q     <= 1'b0;
         nib_q       <= '0;
         word_q      <= '0;
         o_req_rdy   <= 1'b0;
         o_wdata_rdy <= 1'b0;
         o_rdata_vld <= 1'b0;
         o_rdata     <= '0;
         o_sqi_sck   <= 1'b0;
         o_sqi_cs_n  <= '1;
         o_sqi_oe    <= 1'b0;
         o_sqi_data  <= 4'h0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         nib_q       <= nib_d;
         word_q      <= word_d;
         o_req_rdy   <= rdy_d;
         o_wdata_rdy <= wrdy_d;
         o_rdata_vld <= rvld_d;
         o_rdata     <= rdata_d;
         o_sqi_sck   <= sck_d;
         o_sqi_cs_n  <= cs_n_d;
         o_sqi_oe    <= oe_d;
         o_sqi_data  <= sdata_d;
      end
   end

   // Request fields and shift registers; only meaningful once a request is latched
   always_ff @(posedge i_clk) begin
      wr_q  <= wr_d;
      cs_q  <= cs_d;
      len_q <= len_d;
      sh_q  <= sh_d;
      rx_q  <= rx_d;
   end

endmodule

// File: tb/tb_idli_sqi_ctrl.sv
// tb_idli_sqi_ctrl: directed bench for idli_sqi_ctrl with a small SQI memory model.
module tb_idli_sqi_ctrl;

   logic        clk = 1'b0;
   logic        i_rst_n;
   logic        i_req_vld, i_req_wr;
   logic [23:0] i_req_addr;
   logic [0:0]  i_req_cs;
   logic [3:0]  i_req_len;
   logic        i_wdata_vld;
   logic [15:0] i_wdata;
   logic        o_req_rdy, o_wdata_rdy, o_rdata_vld;
   logic [15:0] o_rdata;
   logic        o_sqi_sck, o_sqi_oe;
   logic [1:0]  o_sqi_cs_n;
   logic [3:0]  o_sqi_data;
   logic [3:0]  i_sqi_data = 4'h0;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   idli_sqi_ctrl #(
      .ADDR_W(24), .DATA_W(16), .NUM_CS(2), .LEN_W(4), .DUMMY_CYC(4),
      .CMD_RD(8'h03), .CMD_WR(8'h02)
   ) dut (
      .i_clk(clk), .i_rst_n(i_rst_n),
      .i_req_vld(i_req_vld), .o_req_rdy(o_req_rdy), .i_req_wr(i_req_wr),
      .i_req_addr(i_req_addr), .i_req_cs(i_req_cs), .i_req_len(i_req_len),
      .i_wdata_vld(i_wdata_vld), .o_wdata_rdy(o_wdata_rdy), .i_wdata(i_wdata),
      .o_rdata_vld(o_rdata_vld), .o_rdata(o_rdata),
      .o_sqi_sck(o_sqi_sck), .o_sqi_cs_n(o_sqi_cs_n), .o_sqi_data(o_sqi_data),
      .o_sqi_oe(o_sqi_oe), .i_sqi_data(i_sqi_data)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // SQI memory model: records nibbles on SCK rise, serves read words after 12 periods
   logic [3:0]  cap[$];
   logic        cap_oe[$];
   logic [15:0] rd_words[4];
   int          scnt = 0;
   logic        prev_act = 1'b0;
   logic        prev_sck = 1'b0;
   logic        act;
   int          mj, mw, mn;

   always @(negedge clk) begin
      act = ~&o_sqi_cs_n;
      if (act && !prev_act) begin
         cap.delete();
         cap_oe.delete();
         scnt = 0;
      end
      if (act && o_sqi_sck && !prev_sck) begin
         cap.push_back(o_sqi_data);
         cap_oe.push_back(o_sqi_oe);
         scnt++;
      end
      if (act && !o_sqi_sck) begin
         if (scnt >= 12) begin
            mj = scnt - 12;
            mw = mj / 4;
            mn = mj % 4;
            if (mw < 4) i_sqi_data = rd_words[mw][(15 - 4*mn) -: 4];
            else        i_sqi_data = 4'h0;
         end else begin
            i_sqi_data = 4'h0;
         end
      end
      prev_act = act;
      prev_sck = o_sqi_sck;
   end

   function automatic logic [15:0] cap_word(input int s);
      if (cap.size() < s + 4) return 16'hxxxx;
      return {cap[s], cap[s+1], cap[s+2], cap[s+3]};
   endfunction

   // Per-cycle log of DUT outputs, cycle 0 = request cycle
   logic [1:0]  cs_log[0:127];
   logic        sck_log[0:127], oe_log[0:127], rdy_log[0:127], rvld_log[0:127], wrdy_log[0:127];
   logic [3:0]  dat_log[0:127];
   logic [15:0] rdat_log[0:127];
   logic [15:0] wwords[4];
   int          wdly[4];

   task automatic run_txn(input int ncyc, input int drop_k, input bit b2b);
      int widx;
      int wcnt;
      widx = 0;
      wcnt = 0;
      for (int k = 0; k < ncyc; k++) begin
         @(negedge clk);
         cs_log[k]   = o_sqi_cs_n;
         sck_log[k]  = o_sqi_sck;
         oe_log[k]   = o_sqi_oe;
         dat_log[k]  = o_sqi_data;
         rdy_log[k]  = o_req_rdy;
         rvld_log[k] = o_rdata_vld;
         rdat_log[k] = o_rdata;
         wrdy_log[k] = o_wdata_rdy;
         if (o_wdata_rdy) begin
            if (widx < 4 && wcnt >= wdly[widx]) begin
               i_wdata_vld = 1'b1;
               i_wdata     = wwords[widx];
               widx++;
               wcnt = 0;
            end else begin
               i_wdata_vld = 1'b0;
               wcnt++;
            end
         end else begin
            i_wdata_vld = 1'b0;
         end
         @(posedge clk);
         #1;
         if (b2b && k == 0) begin
            i_req_wr   = 1'b1;
            i_req_addr = 24'h000020;
         end
         if (k == drop_k) i_req_vld = 1'b0;
      end
      i_req_vld   = 1'b0;
      i_wdata_vld = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]  exp_n[8];
      logic [23:0] a;
      int          cnt;
      i_rst_n = 1'b0; i_req_vld = 1'b0; i_req_wr = 1'b0; i_req_addr = '0;
      i_req_cs = '0; i_req_len = '0; i_wdata_vld = 1'b0; i_wdata = '0;
      rd_words = '{16'h0, 16'h0, 16'h0, 16'h0};
      wwords = '{16'h0, 16'h0, 16'h0, 16'h0};
      wdly = '{0, 0, 0, 0};

      // ---- reset held 3 cycles ----
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_cs_n", 32'(o_sqi_cs_n), 'h3);
      check("rst_sck", 32'(o_sqi_sck), 0);
      check("rst_oe", 32'(o_sqi_oe), 0);
      check("rst_data", 32'(o_sqi_data), 0);
      check("rst_rdy_low", 32'(o_req_rdy), 0);
      check("rst_rvld", 32'(o_rdata_vld), 0);
      check("rst_rdata", 32'(o_rdata), 0);
      @(posedge clk); #1;
      i_rst_n = 1'b1;
      @(negedge clk);
      check("rst_rdy_release_cycle", 32'(o_req_rdy), 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_rdy_after", 32'(o_req_rdy), 1);
      @(posedge clk); #1;

      // ---- single read ----
      rd_words = '{16'hBEEF, 16'h0, 16'h0, 16'h0};
      i_req_wr = 1'b0; i_req_addr = 24'h123456; i_req_cs = 1'b1; i_req_len = 4'd0; i_req_vld = 1'b1;
      run_txn(40, 0, 1'b0);
      exp_n = '{4'h0, 4'h3, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
      check("rd1_rdy0", 32'(rdy_log[0]), 1);
      check("rd1_cs_first", 32'(cs_log[1]), 'h1);
      check("rd1_sck_p0", 32'(sck_log[1]), 0);
      check("rd1_sck_p1", 32'(sck_log[2]), 1);
      for (int k = 0; k < 8; k++)
         check($sformatf("rd1_nib%0d", k), 32'(dat_log[1 + 2*k]), 32'(exp_n[k]));
      cnt = 0;
      for (int k = 17; k <= 24; k++) cnt += int'(oe_log[k]);
      check("rd1_dummy_oe", cnt, 0);
      cnt = 0;
      for (int k = 17; k <= 24; k++) cnt += int'(sck_log[k]);
      check("rd1_dummy_sck_periods", cnt, 4);
      check("rd1_cap_size", cap.size(), 16);
      check("rd1_cs_last_data", 32'(cs_log[32]), 'h1);
      check("rd1_cs_done", 32'(cs_log[33]), 'h3);
      check("rd1_rvld33", 32'(rvld_log[33]), 1);
      check("rd1_rdata33", 32'(rdat_log[33]), 'hBEEF);
      cnt = 0;
      for (int k = 0; k < 40; k++) cnt += int'(rvld_log[k]);
      check("rd1_rvld_count", cnt, 1);
      check("rd1_rdy34", 32'(rdy_log[34]), 0);
      check("rd1_rdy35", 32'(rdy_log[35]), 1);

      // ---- burst read of 4 words ----
      rd_words = '{16'hA5C3, 16'h0F1E, 16'h7788, 16'h1234};
      i_req_wr = 1'b0; i_req_addr = 24'h000100; i_req_cs = 1'b0; i_req_len = 4'd3; i_req_vld = 1'b1;
      run_txn(64, 0, 1'b0);
      check("rd4_cs_first", 32'(cs_log[1]), 'h2);
      cnt = 0;
      for (int k = 0; k < 64; k++) cnt += int'(rvld_log[k]);
      check("rd4_rvld_count", cnt, 4);
      for (int w = 0; w < 4; w++) begin
         check($sformatf("rd4_rvld_w%0d", w), 32'(rvld_log[33 + 8*w]), 1);
         check($sformatf("rd4_rdata_w%0d", w), 32'(rdat_log[33 + 8*w]), 32'(rd_words[w]));
      end
      cnt = 0;
      for (int k = 1; k < 64; k++) if (cs_log[k] != 2'b11 && cs_log[k-1] == 2'b11) cnt++;
      check("rd4_cs_assertions", cnt, 1);
      check("rd4_rdy58", 32'(rdy_log[58]), 0);
      check("rd4_rdy59", 32'(rdy_log[59]), 1);

      // ---- write of 2 words, second one stalled ----
      wwords = '{16'h1234, 16'h5678, 16'h0, 16'h0};
      wdly = '{0, 5, 0, 0};
      i_req_wr = 1'b1; i_req_addr = 24'h00ABCD; i_req_cs = 1'b0; i_req_len = 4'd1; i_req_vld = 1'b1;
      run_txn(46, 0, 1'b0);
      check("wr_wrdy16", 32'(wrdy_log[16]), 0);
      check("wr_wrdy17", 32'(wrdy_log[17]), 1);
      check("wr_sck_data_p0", 32'(sck_log[18]), 0);
      check("wr_sck_data_p1", 32'(sck_log[19]), 1);
      cnt = 0;
      for (int k = 26; k <= 30; k++) if (sck_log[k] == 1'b0 && cs_log[k] == 2'b10 && wrdy_log[k]) cnt++;
      check("wr_stall_cycles", cnt, 5);
      check("wr_wrdy31", 32'(wrdy_log[31]), 1);
      check("wr_wrdy32", 32'(wrdy_log[32]), 0);
      check("wr_cap_size", cap.size(), 16);
      check("wr_cmd_hi", 32'(cap[0]), 0);
      check("wr_cmd_lo", 32'(cap[1]), 2);
      a = '0;
      for (int k = 2; k < 8; k++) a = (a << 4) | 24'(cap[k]);
      check("wr_addr", 32'(a), 'h00ABCD);
      check("wr_word0", 32'(cap_word(8)), 'h1234);
      check("wr_word1", 32'(cap_word(12)), 'h5678);
      cnt = 0;
      for (int k = 0; k < cap_oe.size(); k++) cnt += int'(cap_oe[k]);
      check("wr_oe_all", cnt, 16);
      check("wr_cs39", 32'(cs_log[39]), 'h2);
      check("wr_cs40", 32'(cs_log[40]), 'h3);
      check("wr_rdy41", 32'(rdy_log[41]), 0);
      check("wr_rdy42", 32'(rdy_log[42]), 1);

      // ---- reset during the address phase of a read ----
      rd_words = '{16'h5555, 16'h0, 16'h0, 16'h0};
      i_req_wr = 1'b0; i_req_addr = 24'h000055; i_req_cs = 1'b1; i_req_len = 4'd0; i_req_vld = 1'b1;
      @(posedge clk); #1;
      i_req_vld = 1'b0;
      repeat (7) @(posedge clk);
      @(negedge clk);
      check("mid_addr_cs", 32'(o_sqi_cs_n), 'h1);
      i_rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_cs_n", 32'(o_sqi_cs_n), 'h3);
      check("mid_rst_sck", 32'(o_sqi_sck), 0);
      check("mid_rst_oe", 32'(o_sqi_oe), 0);
      check("mid_rst_rdy", 32'(o_req_rdy), 0);
      i_rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("mid_rel_rdy", 32'(o_req_rdy), 1);
      cnt = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         cnt += int'(o_rdata_vld);
         if (o_sqi_cs_n != 2'b11) cnt += 100;
      end
      check("mid_no_rvld_no_cs", cnt, 0);
      @(posedge clk); #1;
      wwords = '{16'hCAFE, 16'h0, 16'h0, 16'h0};
      wdly = '{0, 0, 0, 0};
      i_req_wr = 1'b1; i_req_addr = 24'h000042; i_req_cs = 1'b1; i_req_len = 4'd0; i_req_vld = 1'b1;
      run_txn(30, 0, 1'b0);
      check("post_cs_first", 32'(cs_log[1]), 'h1);
      check("post_wrdy17", 32'(wrdy_log[17]), 1);
      check("post_cap_size", cap.size(), 12);
      check("post_word", 32'(cap_word(8)), 'hCAFE);
      check("post_rdy27", 32'(rdy_log[27]), 0);
      check("post_rdy28", 32'(rdy_log[28]), 1);

      // ---- back-to-back read then write, request held ----
      rd_words = '{16'h9ABC, 16'h0, 16'h0, 16'h0};
      wwords = '{16'h4321, 16'h0, 16'h0, 16'h0};
      i_req_wr = 1'b0; i_req_addr = 24'h000010; i_req_cs = 1'b0; i_req_len = 4'd0; i_req_vld = 1'b1;
      run_txn(66, 35, 1'b1);
      check("b2b_rvld33", 32'(rvld_log[33]), 1);
      check("b2b_rdata33", 32'(rdat_log[33]), 'h9ABC);
      check("b2b_cs32", 32'(cs_log[32]), 'h2);
      cnt = 0;
      for (int k = 33; k <= 36; k++) if (cs_log[k] == 2'b11) cnt++;
      check("b2b_cs_gap", cnt, 3);
      check("b2b_cs36", 32'(cs_log[36]), 'h2);
      check("b2b_rdy35", 32'(rdy_log[35]), 1);
      check("b2b_cmd_hi", 32'(dat_log[36]), 0);
      check("b2b_cmd_lo", 32'(dat_log[38]), 2);
      check("b2b_oe36", 32'(oe_log[36]), 1);
      check("b2b_word", 32'(cap_word(8)), 'h4321);
      check("b2b_rdy63", 32'(rdy_log[63]), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
